// File: rtl/bias_pkg.sv
// Shared constants and state type for the fire5_squeeze bias loader.
// Pure declarations: no logic, no latency, no flow control.
package bias_pkg;

  localparam int FIRE5_SQ_N_CH  = 32;
  localparam int BIAS_W         = 32;
  localparam int BYTES_PER_WORD = BIAS_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } bias_ld_state_t;

endpackage

// File: rtl/bias_word_assembler.sv
// Packs little-endian bytes into a DATA_W word; word/word_done are valid in the
// same cycle the last byte is accepted. Consumes one byte per byte_en, never stalls.
module bias_word_assembler
  import bias_pkg::*;
#(
  parameter int DATA_W = BIAS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              byte_en,
  input  logic [7:0]        s_data,
  output logic [DATA_W-1:0] word,
  output logic              word_done
);

  localparam int BPW   = DATA_W / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BPW - 1);

  logic [CNT_W-1:0]  bcnt;
  logic [DATA_W-1:0] hold;

  // Merge the incoming byte combinationally so the completed word can be
  // committed on the same edge that accepts its last byte.
  always_comb begin
    word = hold;
    if (byte_en) begin
      word[8*bcnt +: 8] = s_data;
    end
  end

  assign word_done = byte_en && (bcnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt <= '0;
      hold <= '0;
    end else if (clr) begin
      bcnt <= '0;
      hold <= '0;
    end else if (byte_en) begin
      hold <= word;
      bcnt <= (bcnt == LAST) ? '0 : bcnt + 1'b1;
    end
  end

endmodule

// File: rtl/bias_loader_fire5_squeeze.sv
// Run-time bias register file loader: start, then N_CH*DATA_W/8 bytes; each word lands
// one cycle after its last byte. s_ready is high only while loading; gaps simply stall.
module bias_loader_fire5_squeeze
  import bias_pkg::*;
#(
  parameter int DATA_W = BIAS_W,
  parameter int N_CH   = FIRE5_SQ_N_CH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] bias_mem [0:N_CH-1],
  output logic              bias_valid,
  output logic              busy
);

  localparam int WIDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [WIDX_W-1:0] WLAST = WIDX_W'(N_CH - 1);

  bias_ld_state_t    state, state_nxt;
  logic [WIDX_W-1:0] widx;
  logic              clr;
  logic              byte_en;
  logic [DATA_W-1:0] word;
  logic              word_done;

  assign s_ready    = (state == LOAD);
  assign busy       = (state == LOAD);
  assign bias_valid = (state == DONE);
  assign byte_en    = s_valid && s_ready;
  // start inside LOAD is ignored, so clearing only happens on entry.
  assign clr        = start && (state != LOAD);

  bias_word_assembler #(
    .DATA_W (DATA_W)
  ) u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .byte_en   (byte_en),
    .s_data    (s_data),
    .word      (word),
    .word_done (word_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (word_done && (widx == WLAST)) state_nxt = DONE;
      DONE:    if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widx <= '0;
    end else if (clr) begin
      widx <= '0;
    end else if (word_done && (widx != WLAST)) begin
      widx <= widx + 1'b1;
    end
  end

  // Entries not yet rewritten keep their old contents during a reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        bias_mem[i] <= '0;
      end
    end else if (word_done) begin
      bias_mem[widx] <= word;
    end
  end

endmodule

// File: tb/tb_bias_loader_fire5_squeeze.sv
// Self-checking bench for bias_loader_fire5_squeeze: fixed and random byte streams,
// random s_valid gaps, start during load, reset mid-load, reload from DONE.
module tb_bias_loader_fire5_squeeze;

  localparam int N_CH = 32;
  localparam int NB   = N_CH * 4;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       start   = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data  = 8'h00;
  logic       s_ready;
  logic       bias_valid;
  logic       busy;
  logic [31:0] bias_mem [0:N_CH-1];

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  ld_bytes [NB];
  logic [31:0] exp_mem  [N_CH];

  typedef struct {
    int          idx;
    logic [31:0] exp;
  } spot_t;
  spot_t spots [6];

  always #5 clk = ~clk;

  bias_loader_fire5_squeeze #(
    .DATA_W (32),
    .N_CH   (N_CH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .bias_mem   (bias_mem),
    .bias_valid (bias_valid),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    for (int i = 0; i < N_CH; i++) begin
      chk($sformatf("%s mem[%0d]", tag, i), bias_mem[i], exp_mem[i]);
    end
  endtask

  task automatic chk_spots(input string tag);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("%s spot[%0d]", tag, spots[i].idx), bias_mem[spots[i].idx], spots[i].exp);
    end
  endtask

  task automatic fill_fixed();
    for (int i = 0; i < N_CH; i++) begin
      case (i)
        0:  begin ld_bytes[4*i] = 8'hA5; ld_bytes[4*i+1] = 8'hFF; ld_bytes[4*i+2] = 8'hFF; ld_bytes[4*i+3] = 8'hFF; end
        13: begin ld_bytes[4*i] = 8'h00; ld_bytes[4*i+1] = 8'h05; ld_bytes[4*i+2] = 8'h00; ld_bytes[4*i+3] = 8'h00; end
        31: begin ld_bytes[4*i] = 8'hF4; ld_bytes[4*i+1] = 8'hFF; ld_bytes[4*i+2] = 8'hFF; ld_bytes[4*i+3] = 8'hFF; end
        default: begin
          ld_bytes[4*i]   = 8'(~i);
          ld_bytes[4*i+1] = 8'h3C;
          ld_bytes[4*i+2] = 8'(i);
          ld_bytes[4*i+3] = 8'hC3;
        end
      endcase
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NB; i++) ld_bytes[i] = 8'($urandom);
  endtask

  // Called at 1 time unit after a rising edge.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("after_start busy", busy, 1);
    chk("after_start s_ready", s_ready, 1);
    chk("after_start bias_valid", bias_valid, 0);
  endtask

  task automatic run_load(input int gap_pct, input int start_at, input int abort_at);
    int n = 0;
    int cyc = 0;
    bit started = 0;
    while (n < NB) begin
      if (n == abort_at) begin
        s_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        for (int i = 0; i < N_CH; i++) exp_mem[i] = '0;
        chk("reset_mid s_ready", s_ready, 0);
        chk("reset_mid busy", busy, 0);
        chk("reset_mid bias_valid", bias_valid, 0);
        chk_mem("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (cyc >= 20 * NB) begin
        vectors++;
        miscompares++;
        $display("FAIL load_timeout: got %0d bytes expected %0d", n, NB);
        s_valid = 1'b0;
        return;
      end
      chk("in_load s_ready", s_ready, 1);
      chk("in_load bias_valid", bias_valid, 0);
      s_valid = ($urandom_range(0, 99) >= gap_pct);
      s_data  = s_valid ? ld_bytes[n] : 8'($urandom);
      start   = (n == start_at) && !started && s_valid;
      if (start) started = 1;
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (s_valid) begin
        if (n % 4 == 3)
          exp_mem[n/4] = {ld_bytes[n], ld_bytes[n-1], ld_bytes[n-2], ld_bytes[n-3]};
        n++;
        if (n == 8) chk_mem("partial");
      end
    end
    chk("last bias_valid", bias_valid, 1);
    chk("last busy", busy, 0);
    chk("last s_ready", s_ready, 0);
    // An extra byte offered right after the last one must be ignored.
    s_valid = 1'b1;
    s_data  = 8'h77;
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("done bias_valid", bias_valid, 1);
    chk_mem("done");
  endtask

  initial begin
    spots[0] = '{0,  32'hFFFFFFA5};
    spots[1] = '{13, 32'h00000500};
    spots[2] = '{31, 32'hFFFFFFF4};
    spots[3] = '{5,  32'hC3053CFA};
    spots[4] = '{12, 32'hC30C3CF3};
    spots[5] = '{30, 32'hC31E3CE1};
    for (int i = 0; i < N_CH; i++) exp_mem[i] = '0;

    #12;
    chk("reset s_ready", s_ready, 0);
    chk("reset busy", busy, 0);
    chk("reset bias_valid", bias_valid, 0);
    chk_mem("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Bytes offered in IDLE are not accepted.
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      @(posedge clk); #1;
      chk("idle s_ready", s_ready, 0);
      chk("idle busy", busy, 0);
    end
    s_valid = 1'b0;
    chk_mem("idle");

    fill_fixed();
    do_start();
    run_load(0, -1, -1);
    chk_spots("full");

    // Reload from DONE with random data, gaps, and a stray start.
    fill_random();
    do_start();
    run_load(30, 50, -1);

    fill_fixed();
    do_start();
    run_load(40, -1, -1);
    chk_spots("gaps");

    fill_random();
    do_start();
    run_load(20, -1, 70);

    fill_fixed();
    do_start();
    run_load(0, -1, -1);
    chk_spots("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bias_loader_fire5_squeeze.md
# bias_loader_fire5_squeeze

Run-time writer for the fire5_squeeze bias memory. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words into a 32-entry register file. It presents the same `bias_mem[0:31]` array the fire5_squeeze datapath already consumes, so biases can be reloaded without resynthesis. It sits between the host/DMA byte port and the fire5_squeeze convolution engine.

## Interface
- `DATA_W`, default 32: bias word width in bits; must be a multiple of 8.
- `N_CH`, default 32: number of output channels, which is also the number of bias entries.
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: single-cycle request to begin a full reload.
- `s_data`  in  8: stream byte.
- `s_valid`  in  1: `s_data` is valid.
- `s_ready`  out  1: loader accepts a byte this cycle.
- `bias_mem`  out  `DATA_W` x [0:`N_CH`-1]: bias words, registered.
- `bias_valid`  out  1: all `N_CH` entries hold a complete, consistent load.
- `busy`  out  1: a load is in progress.

## Operation
- States: IDLE, LOAD, DONE.
  - IDLE to LOAD on `start`.
  - LOAD to DONE when the final byte of entry `N_CH`-1 is accepted.
  - DONE to LOAD on `start`.
- A byte transfer occurs only in a cycle where `s_valid` and `s_ready` are both 1.
- `s_ready` is 1 only in LOAD. It is a pure decode of state and does not depend on `s_valid`.
- Byte assembly:
  - The byte counter `bcnt` runs from 0 to `DATA_W`/8-1.
  - Byte k is written to bits [8k+7:8k] of the word shift/holding register.
  - When the last byte is accepted, the completed word is written to `bias_mem[widx]`, `bcnt` wraps to 0 and `widx` increments.
- Word index: `widx` runs from 0 to `N_CH`-1. It does not wrap inside a load; the final word ends the load.
- No sign extension or arithmetic is applied. Words are stored exactly as received.
- On entry to LOAD, `bcnt` and `widx` clear to 0 and `bias_valid` clears to 0.
- Entries not yet rewritten keep their previous values during a reload.
- `start` received while in LOAD is ignored. The load continues, with no restart and no error.
- Bytes offered in IDLE or DONE are not accepted (`s_ready`=0) and have no effect.
- Reset mid-load:
  - All state returns to reset values immediately (asynchronous).
  - The partially assembled word is discarded.
- Reset values:
  - State IDLE.
  - `s_ready`=0, `busy`=0, `bias_valid`=0.
  - `bcnt`=0, `widx`=0.
  - Every `bias_mem` entry is 0.

## Timing
- `start` sampled at edge t: state is LOAD and `s_ready`=1 from cycle t+1.
- Each accepted byte at edge t is visible in internal state at t+1.
- A completed word accepted at edge t appears on `bias_mem[widx]` in cycle t+1.
- Last byte accepted at edge t:
  - In cycle t+1: `bias_mem[N_CH-1]` is updated, `bias_valid`=1, `busy`=0 and `s_ready`=0.
  - No extra byte can be consumed at t+1.
- Minimum load time is `N_CH`·`DATA_W`/8 accepted cycles (128 at defaults) plus 1 cycle for `start`.
- Gaps in `s_valid` stall the load with no state change.
- `busy` = (state == LOAD).
- `bias_valid` is 1 only in DONE.

## Structure
- Shared package `bias_pkg` holds:
  - `FIRE5_SQ_N_CH`=32 and `BIAS_W`=32;
  - the state enum `bias_ld_state_t` {IDLE, LOAD, DONE};
  - `BYTES_PER_WORD` = `BIAS_W`/8.
- One sub-module, `bias_word_assembler`:
  - contains the byte counter and holding register;
  - inputs: `clk`, `rst_n`, `clr`, `byte_en`, `s_data`;
  - outputs: `word`, `word_done` (a one-cycle pulse aligned with the last byte's acceptance).
- The top level contains the FSM, `widx` and the register-file write.

## Test plan
- Reset: hold `rst_n`=0 → all `bias_mem`=0, `s_ready`=0, `bias_valid`=0, `busy`=0.
- Full load:
  - Stimulus: `start`, then 128 back-to-back bytes. Entry 0 is A5 FF FF FF, entry 13 is 00 05 00 00, entry 31 is F4 FF FF FF.
  - Required: `bias_mem[0]`=32'hFFFFFFA5, `bias_mem[13]`=32'h00000500, `bias_mem[31]`=32'hFFFFFFF4, and `bias_valid`=1 exactly one cycle after the 128th byte.
- Backpressure and gaps:
  - Stimulus: randomly deassert `s_valid` during the load.
  - Required: contents identical to the full-load case, and no byte dropped or duplicated.
- `start` during LOAD: pulse `start` after 50 bytes → the load still completes after byte 128 with correct contents.
- Reset mid-load: assert `rst_n`=0 after 70 bytes, then perform a fresh full load → `bias_mem` is all 0 after reset and correct after the new load.
- Reload from DONE:
  - Stimulus: `start` in DONE.
  - Required: `bias_valid` drops the next cycle; entries 1–31 keep their old values until rewritten; the new values are in place after 128 bytes.
